// File: rtl/table3x4_scan_pkg.sv
// Shared definitions for the 3x4 table scanner: FSM encoding, table
// geometry, index widths and the word the selector returns when no row
// is selected.
package table3x4_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam int NUM_ROWS    = 3;
    localparam int NUM_COLS    = 4;
    localparam int NUM_ENTRIES = 12;
    localparam int IDX_W       = 4;
    localparam int ROW_W       = 3;   // one-hot row select
    localparam int ROW_IDX_W   = 2;   // binary row number
    localparam int COL_W       = 2;
    localparam int DATA_W      = 32;

    localparam logic [DATA_W-1:0] IDLE_WORD = 32'hDEADBEEF;

    // Row number to the one-hot select the table selector expects.
    function automatic logic [ROW_W-1:0] row_onehot(input logic [ROW_IDX_W-1:0] r);
        row_onehot = 3'b001 << r;
    endfunction

    // row*4 + col; with four columns this is a plain concatenation.
    function automatic logic [IDX_W-1:0] entry_index(input logic [ROW_IDX_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
        entry_index = {r, c};
    endfunction

endpackage

// File: rtl/table3x4_scan_if.sv
// Valid/ready stream carrying one table word plus its entry index and
// end-of-scan marker from the scanner to its consumer.
interface table3x4_scan_if;
    import table3x4_scan_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/table3x4_scan_idx.sv
// Entry walker for the 3x4 table. Holds the current row/column, steps
// through the table in row-major or column-major order and flags the
// twelfth entry. Once stepped past the twelfth entry the selects go to
// zero so the selector is left idle.
module table3x4_scan_idx
    import table3x4_scan_pkg::*;
#(
    parameter bit ROW_MAJOR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    output logic [COL_W-1:0]     sel_col,
    output logic [ROW_W-1:0]     sel_row,
    output logic [IDX_W-1:0]     idx,
    output logic                 last
);

    logic [ROW_IDX_W-1:0] row_q;
    logic [COL_W-1:0]     col_q;
    logic                 past_end_q;
    logic                 at_end;
    logic                 row_wrap;
    logic                 col_wrap;

    // Both orders finish on row 2, column 3.
    assign row_wrap = (row_q == ROW_IDX_W'(NUM_ROWS - 1));
    assign col_wrap = (col_q == COL_W'(NUM_COLS - 1));
    assign at_end   = row_wrap && col_wrap;

    // Advance the row/column pair in the configured order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            row_q      <= '0;
            col_q      <= '0;
            past_end_q <= 1'b0;
        end else if (adv && !past_end_q) begin
            if (at_end) begin
                past_end_q <= 1'b1;
            end else if (ROW_MAJOR) begin
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_IDX_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end else begin
                if (row_wrap) begin
                    row_q <= '0;
                    col_q <= col_q + COL_W'(1);
                end else begin
                    row_q <= row_q + ROW_IDX_W'(1);
                end
            end
        end
    end

    assign sel_col = past_end_q ? '0 : col_q;
    assign sel_row = past_end_q ? '0 : row_onehot(row_q);
    assign idx     = entry_index(row_q, col_q);
    assign last    = at_end && !past_end_q;

endmodule

// File: rtl/table3x4_scan.sv
// table3x4_scan: walks all twelve entries of the 3x4 table through the
// downstream combinational selector and streams each word out over a
// valid/ready handshake. Build option TABLE3X4_SCAN_CHECKSUM_EN adds a
// running 32-bit sum of the transferred words; without it checksum is 0.
module table3x4_scan
    import table3x4_scan_pkg::*;
#(
    parameter bit ROW_MAJOR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [COL_W-1:0]   sel_col,
    output logic [ROW_W-1:0]   sel_row,
    input  logic [DATA_W-1:0]  sel_data,
    table3x4_scan_if.master    out_if,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  checksum
);

    state_t             state_q;
    state_t             state_d;
    logic               capture;
    logic               done_d;
    logic               done_q;
    logic               hs;
    logic               valid;
    logic               accept;
    logic [DATA_W-1:0]  data_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;
    logic [COL_W-1:0]   cur_col;
    logic [ROW_W-1:0]   cur_row;
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_last;

    table3x4_scan_idx #(
        .ROW_MAJOR (ROW_MAJOR)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == ST_IDLE),
        .adv     (capture),
        .sel_col (cur_col),
        .sel_row (cur_row),
        .idx     (cur_idx),
        .last    (cur_last)
    );

    assign valid  = (state_q == ST_SEND);
    assign hs     = valid && out_if.out_ready;
    assign accept = (state_q == ST_IDLE) && start && !abort;

    // The selector must see no row while idle, even straight after an abort.
    assign sel_col = (state_q == ST_IDLE) ? '0 : cur_col;
    assign sel_row = (state_q == ST_IDLE) ? '0 : cur_row;

    // Next state, word capture and completion pulse; abort always wins.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hs) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Output word register; only changes on fetch or an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (capture) begin
            data_q <= sel_data;
            idx_q  <= cur_idx;
            last_q <= cur_last;
        end
    end

`ifdef TABLE3X4_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Running sum of transferred words, including one accepted alongside abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (hs) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign out_if.out_data  = data_q;
    assign out_if.out_idx   = idx_q;
    assign out_if.out_valid = valid;
    assign out_if.out_last  = last_q && valid;
    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;

endmodule

// File: tb/tb_table3x4_scan.sv
// Bench for table3x4_scan: one row-major and one column-major instance
// share stimulus; a transaction-level model predicts each cycle's outputs.
module tb_table3x4_scan;
    import table3x4_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_ready = 1'b0;

    logic [1:0]  sel_col_a[2];
    logic [2:0]  sel_row_a[2];
    logic [31:0] sel_data_a[2];
    logic        busy_a[2];
    logic        done_a[2];
    logic [31:0] csum_a[2];
    logic [31:0] data_a[2];
    logic [3:0]  idx_a[2];
    logic        valid_a[2];
    logic        last_a[2];

    int n_checks = 0;
    int n_fail = 0;
    int dut_hs = 0;

    // reference model state
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_done = 1'b0;
    int          m_pos = 0;
    int          m_xfers = 0;
    logic [31:0] m_sum[2];

`ifdef TABLE3X4_SCAN_CHECKSUM_EN
    localparam logic CSUM_ON = 1'b1;
`else
    localparam logic CSUM_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    table3x4_scan_if if0 ();
    table3x4_scan_if if1 ();

    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    table3x4_scan #(.ROW_MAJOR(1'b1)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .sel_col (sel_col_a[0]), .sel_row (sel_row_a[0]), .sel_data (sel_data_a[0]),
        .out_if (if0), .busy (busy_a[0]), .done (done_a[0]), .checksum (csum_a[0])
    );

    table3x4_scan #(.ROW_MAJOR(1'b0)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
        .sel_col (sel_col_a[1]), .sel_row (sel_row_a[1]), .sel_data (sel_data_a[1]),
        .out_if (if1), .busy (busy_a[1]), .done (done_a[1]), .checksum (csum_a[1])
    );

    // Table selector: entry (r,c) = 0x100*r + c, default word when no row.
    function automatic logic [31:0] table_word(input logic [2:0] r, input logic [1:0] c);
        case (r)
            3'b001:  table_word = 32'h000 + {30'b0, c};
            3'b010:  table_word = 32'h100 + {30'b0, c};
            3'b100:  table_word = 32'h200 + {30'b0, c};
            default: table_word = IDLE_WORD;
        endcase
    endfunction

    assign sel_data_a[0] = table_word(sel_row_a[0], sel_col_a[0]);
    assign sel_data_a[1] = table_word(sel_row_a[1], sel_col_a[1]);

    assign data_a[0] = if0.out_data;   assign data_a[1] = if1.out_data;
    assign idx_a[0] = if0.out_idx;     assign idx_a[1] = if1.out_idx;
    assign valid_a[0] = if0.out_valid; assign valid_a[1] = if1.out_valid;
    assign last_a[0] = if0.out_last;   assign last_a[1] = if1.out_last;

    // Entry index delivered at sequence position p (d=0 row-major, d=1 column-major).
    function automatic int exp_idx(input int d, input int p);
        if (d == 0) return p;
        return (p % 3) * 4 + p / 3;
    endfunction

    function automatic logic [31:0] exp_word(input int idx);
        return 32'(32'h100 * (idx / 4) + idx % 4);
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        logic hs;
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0;
            m_pos = 0; m_xfers = 0;
            m_sum[0] = '0; m_sum[1] = '0;
            return;
        end
        m_done = 1'b0;
        hs = m_valid && out_ready;
        if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1'b1; m_pos = 0; m_xfers = 0;
                m_sum[0] = '0; m_sum[1] = '0;
            end
        end else begin
            if (hs) begin
                for (int d = 0; d < 2; d++) m_sum[d] = m_sum[d] + exp_word(exp_idx(d, m_pos));
                m_xfers++;
            end
            if (abort) begin
                m_busy = 1'b0; m_valid = 1'b0;
            end else if (!m_valid) begin
                m_valid = 1'b1;
            end else if (hs) begin
                if (m_pos == NUM_ENTRIES - 1) begin
                    m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    task automatic check_all();
        int nidx;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("busy[%0d]", d), busy_a[d], m_busy);
            chk_eq($sformatf("valid[%0d]", d), valid_a[d], m_valid);
            chk_eq($sformatf("done[%0d]", d), done_a[d], m_done);
            chk_eq($sformatf("checksum[%0d]", d), csum_a[d], CSUM_ON ? m_sum[d] : 32'h0);
            if (m_valid) begin
                chk_eq($sformatf("data[%0d]", d), data_a[d], exp_word(exp_idx(d, m_pos)));
                chk_eq($sformatf("idx[%0d]", d), idx_a[d], exp_idx(d, m_pos));
                chk_eq($sformatf("last[%0d]", d), last_a[d], m_pos == NUM_ENTRIES - 1);
            end
            if (!m_busy) begin
                chk_eq($sformatf("idle_sel_row[%0d]", d), sel_row_a[d], 0);
                chk_eq($sformatf("idle_sel_col[%0d]", d), sel_col_a[d], 0);
            end else if (m_valid && m_pos == NUM_ENTRIES - 1) begin
                chk_eq($sformatf("end_sel_row[%0d]", d), sel_row_a[d], 0);
            end else begin
                nidx = exp_idx(d, m_valid ? m_pos + 1 : 0);
                chk_eq($sformatf("sel_row[%0d]", d), sel_row_a[d], 32'(3'b001 << (nidx / 4)));
                chk_eq($sformatf("sel_col[%0d]", d), sel_col_a[d], nidx % 4);
            end
        end
    endtask

    task automatic tick();
        if (valid_a[0] === 1'b1 && out_ready) dut_hs++;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60 && !m_done; i++) tick();
        chk_eq(tag, m_done, 1'b1);
    endtask

    initial begin
        m_sum[0] = '0; m_sum[1] = '0;

        // reset values
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("rst_data[%0d]", d), data_a[d], 0);
            chk_eq($sformatf("rst_idx[%0d]", d), idx_a[d], 0);
        end
        rst_n = 1'b1;
        tick();

        // full scan with consumer always ready
        out_ready = 1'b1;
        pulse_start();
        chk_eq("fetch_no_valid", valid_a[0], 1'b0);
        tick();
        chk_eq("first_valid", valid_a[0], 1'b1);
        wait_done("full_done");
        chk_eq("full_sum", csum_a[0], CSUM_ON ? 32'h00000C12 : 32'h0);
        chk_eq("full_busy_in_done", busy_a[0], 1'b0);

        // back-to-back start in the done cycle, then a stall at entry 5
        dut_hs = 0;
        pulse_start();
        for (int i = 0; i < 40 && !(m_valid && m_pos == 5); i++) tick();
        chk_eq("reach_idx5", idx_a[0], 5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("stall_data", data_a[0], 32'h101);
        end
        out_ready = 1'b1;
        tick();
        chk_eq("resume_data", data_a[0], 32'h102);
        wait_done("stall_done");
        chk_eq("stall_xfers", dut_hs, 12);

        // abort after the fourth transfer
        tick();
        pulse_start();
        for (int i = 0; i < 40 && m_xfers < 4; i++) tick();
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("abort_valid", valid_a[0], 1'b0);
        chk_eq("abort_sum", csum_a[0], CSUM_ON ? 32'h6 : 32'h0);
        tick();
        chk_eq("abort_no_done", done_a[0], 1'b0);
        out_ready = 1'b1;
        pulse_start();
        tick();
        chk_eq("restart_idx", idx_a[0], 0);

        // reset in the middle of a scan
        for (int i = 0; i < 40 && !(m_valid && m_pos == 7); i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk_eq($sformatf("midrst_data[%0d]", d), data_a[d], 0);
            chk_eq($sformatf("midrst_idx[%0d]", d), idx_a[d], 0);
        end
        tick();

        // start while busy is ignored; start with abort in idle does nothing
        pulse_start();
        for (int i = 0; i < 4; i++) pulse_start();
        wait_done("busy_start_done");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_eq("start_abort_idle", busy_a[0], 1'b0);
        tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom % 6) == 0;
            abort = ($urandom % 45) == 0;
            out_ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 200) != 0;
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/table3x4_scan.md
# table3x4_scan

Sequencer that walks all twelve entries of the 3x4 word table, one entry at a time. It drives the column/row select lines of the combinational 3x4 table selector that sits directly downstream and registers the word returned. Each word is streamed to a consumer over a valid/ready handshake. Used by the debug/dump path to read out a whole table without software address arithmetic.

## Interface
- `ROW_MAJOR`, default 1: 1 = column index fastest (row 0 col 0..3, then row 1 …); 0 = row index fastest (col 0 row 0..2, then col 1 …).
- `clk`  in  1  system clock; all logic rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `abort`  in  1  terminate the scan; return to IDLE.
- `sel_col`  out  2  column select to the table selector.
- `sel_row`  out  3  row select to the table selector, one-hot: bit0 = row 0, bit1 = row 1, bit2 = row 2.
- `sel_data`  in  32  selected word returned combinationally by the table selector.
- `out_data`  out  32  captured table word.
- `out_idx`  out  4  entry index of `out_data` = row*4 + col (0..11).
- `out_valid`  out  1  `out_data`/`out_idx`/`out_last` valid.
- `out_ready`  in  1  consumer accepts.
- `out_last`  out  1  current word is the 12th of the scan.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last handshake of a completed scan.
- `checksum`  out  32  running sum; see Configuration.

## Operation
- States:
  - IDLE, FETCH and SEND.
  - IDLE:
    - `start`=1 and `abort`=0 → FETCH.
    - Fetch index (`fidx`) cleared to 0.
  - FETCH:
    - `sel_*` drive entry `fidx`.
    - At the clock edge, `out_data` ← `sel_data`, `out_idx` ← `fidx`, `fidx` advances → SEND.
  - SEND:
    - `out_valid`=1.
    - `sel_*` drive the next entry `fidx` while holding.
    - On handshake (`out_valid`&`out_ready`):
      - If not last: capture `sel_data`, `out_idx` ← `fidx`, `fidx` advances, stay in SEND.
      - If last: → IDLE, `done` pulses in the following cycle.
- Index walk:
  - Row-major: fidx = row*4+col, increments 0..11.
  - Column-major: order 0,4,8,1,5,9,2,6,10,3,7,11.
  - `out_idx` always reports row*4+col, never the sequence position.
  - `out_last` = (sequence position == 11).
  - After position 11, `sel_row` = 3'b000.
- `out_data`, `out_idx` and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.
- `abort`:
  - Highest priority in every state; → IDLE on the next edge.
  - `out_valid` drops; no `done`.
  - A handshake in the same cycle as `abort` counts as transferred.
  - Concurrent `start`+`abort` in IDLE: stay IDLE.
- `start` while `busy`: ignored.
- In IDLE: `sel_row`=3'b000, `sel_col`=2'b00. This makes the selector output its default word.

## Timing
- Reset values:
  - State IDLE.
  - `sel_col`=0, `sel_row`=0, `out_data`=0, `out_idx`=0.
  - `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `checksum`=0.
- Reset mid-scan: the same as the reset values; no `done`.
- Latency:
  - `start` sampled at edge N → FETCH in cycle N+1.
  - `out_valid`=1 from edge N+2.
- Throughput: with `out_ready` held 1, 12 transfers in 12 consecutive cycles.
- `done`=1 for exactly one cycle, starting at the edge after the last handshake. `busy`=0 in that same cycle.
- The next `start` is accepted in the `done` cycle.
- `sel_data` is combinational from `sel_*`. Its path is a single-cycle path through the selector.

## Configuration
- `TABLE3X4_SCAN_CHECKSUM_EN` defined:
  - `checksum` = 32-bit wrapping sum of every handshaken `out_data` in the current scan.
  - Cleared when `start` is accepted.
  - Final value valid from the `done` cycle; held until the next accepted `start`.
  - After `abort`, holds the partial sum.
- Not defined: the `checksum` port remains and is tied to 32'h0. No adder is synthesised.

## Structure
- Shared package: state encoding (IDLE/FETCH/SEND), entry count 12, index width 4, row/col widths, and the idle selector default word 32'hDEADBEEF (for bench checks).
- Sub-module `table3x4_scan_idx`: the index counter plus order mapping (ROW_MAJOR). It outputs `sel_col`, one-hot `sel_row`, row*4+col, and the last flag.

## Test plan
- Table entry (r,c) = 32'h100*r + c, ROW_MAJOR=1, `out_ready`=1, pulse `start` → data 0x000,0x001,0x002,0x003,0x100 … 0x203 with `out_idx` 0..11. `out_last` on 0x203; `done` one cycle later; `checksum`=32'h00000C12 (macro on) / 0 (macro off).
- ROW_MAJOR=0, same table → data 0x000,0x100,0x200,0x001 … 0x203; `out_idx` 0,4,8,1 … 11.
- `out_ready` low for 3 cycles while `out_idx`=5 → `out_data`=0x101 held stable; the scan resumes with 0x102 and the total is still 12 transfers.
- `abort` after the 4th handshake → IDLE next cycle, `out_valid`=0, no `done`, `checksum`=0x006. A new `start` restarts at idx 0.
- `rst_n`=0 for one cycle mid-scan (idx 7) → all outputs at reset values next cycle. `start` pulsed while `busy` → ignored. `start`+`abort` in IDLE → no scan.
